// File: rtl/alarm_ctrl_if.sv
// Signal bundle between the alarm sequencer, the user-button logic and the alarm comparator.
// The slave modport is the sequencer's view; master is the driving environment.
interface alarm_ctrl_if;
  logic       sec_tick;
  logic [5:0] curr_minutes;
  logic [4:0] curr_hours;
  logic [5:0] user_alarm_minutes;
  logic [4:0] user_alarm_hours;
  logic       user_set;
  logic       alarm_enable;
  logic       snooze_btn;
  logic       dismiss_btn;
  logic       alarm_trigger;
  logic       set_alarm;
  logic [5:0] new_alarm_minutes;
  logic [4:0] new_alarm_hours;
  logic       ringing;
  logic       snooze_active;
  logic [1:0] snooze_count;

  modport slave (
    input  sec_tick, curr_minutes, curr_hours, user_alarm_minutes, user_alarm_hours,
    input  user_set, alarm_enable, snooze_btn, dismiss_btn, alarm_trigger,
    output set_alarm, new_alarm_minutes, new_alarm_hours, ringing, snooze_active, snooze_count
  );

  modport master (
    output sec_tick, curr_minutes, curr_hours, user_alarm_minutes, user_alarm_hours,
    output user_set, alarm_enable, snooze_btn, dismiss_btn, alarm_trigger,
    input  set_alarm, new_alarm_minutes, new_alarm_hours, ringing, snooze_active, snooze_count
  );
endinterface

// File: rtl/alarm_ctrl.sv
// Alarm session sequencer: owns the base alarm time, programs the comparator and turns its
// level trigger into a ring / snooze / dismiss session with ring timeout and snooze limit.
module alarm_ctrl #(
  parameter int SNOOZE_MIN     = 5,
  parameter int RING_TIMEOUT_S = 60,
  parameter int MAX_SNOOZES    = 3
) (
  input  logic        clk,
  input  logic        rst,
  alarm_ctrl_if.slave bus
);

  localparam int CNT_W = (RING_TIMEOUT_S > 1) ? $clog2(RING_TIMEOUT_S + 1) : 1;

  typedef enum logic [1:0] {UNSET, ARMED, RINGING, SNOOZED} state_t;

  state_t           state;
  logic             trig_d;
  logic [5:0]       base_minutes;
  logic [4:0]       base_hours;
  logic [CNT_W-1:0] ring_cnt;
  logic             set_alarm_r;
  logic [5:0]       new_minutes_r;
  logic [4:0]       new_hours_r;
  logic             ringing_r;
  logic             snooze_active_r;
  logic [1:0]       snooze_cnt;

  logic             trig_rise;
  logic             in_session;
  logic             snooze_ok;
  logic             timeout;
  logic             do_dismiss;
  logic             ring_start;
  logic [10:0]      snooze_hm;

  // Current time plus SNOOZE_MIN, carrying into hours and wrapping 23 -> 0.
  function automatic logic [10:0] snooze_target(input logic [5:0] m, input logic [4:0] h);
    logic [6:0] sum;
    logic [6:0] wrapped;
    logic [4:0] next_h;
    sum = {1'b0, m} + 7'(SNOOZE_MIN);
    if (sum >= 7'd60) begin
      wrapped = sum - 7'd60;
      next_h  = (h == 5'd23) ? 5'd0 : h + 5'd1;
      return {next_h, wrapped[5:0]};
    end
    return {h, sum[5:0]};
  endfunction

  always_comb begin
    trig_rise  = bus.alarm_trigger & ~trig_d;
    in_session = (state == RINGING) || (state == SNOOZED);
    snooze_ok  = (state == RINGING) && bus.snooze_btn && (32'(snooze_cnt) < MAX_SNOOZES);
    timeout    = (state == RINGING) && bus.sec_tick &&
                 (ring_cnt == CNT_W'(RING_TIMEOUT_S - 1));
    // Snooze outranks a timeout landing on the same tick; button/enable dismisses outrank both.
    do_dismiss = (in_session && (bus.dismiss_btn || !bus.alarm_enable)) || (timeout && !snooze_ok);
    ring_start = ((state == ARMED) || (state == SNOOZED)) && trig_rise && bus.alarm_enable;
    snooze_hm  = snooze_target(bus.curr_minutes, bus.curr_hours);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= UNSET;
      trig_d          <= 1'b0;
      base_minutes    <= '0;
      base_hours      <= '0;
      ring_cnt        <= '0;
      set_alarm_r     <= 1'b0;
      new_minutes_r   <= '0;
      new_hours_r     <= '0;
      ringing_r       <= 1'b0;
      snooze_active_r <= 1'b0;
      snooze_cnt      <= '0;
    end else begin
      trig_d      <= bus.alarm_trigger;
      set_alarm_r <= 1'b0;
      if (bus.user_set) begin
        base_minutes    <= bus.user_alarm_minutes;
        base_hours      <= bus.user_alarm_hours;
        new_minutes_r   <= bus.user_alarm_minutes;
        new_hours_r     <= bus.user_alarm_hours;
        set_alarm_r     <= 1'b1;
        snooze_cnt      <= '0;
        state           <= ARMED;
        ringing_r       <= 1'b0;
        snooze_active_r <= 1'b0;
      end else if (state != UNSET) begin
        if (do_dismiss) begin
          new_minutes_r   <= base_minutes;
          new_hours_r     <= base_hours;
          set_alarm_r     <= 1'b1;
          snooze_cnt      <= '0;
          state           <= ARMED;
          ringing_r       <= 1'b0;
          snooze_active_r <= 1'b0;
        end else if (snooze_ok) begin
          new_minutes_r   <= snooze_hm[5:0];
          new_hours_r     <= snooze_hm[10:6];
          set_alarm_r     <= 1'b1;
          snooze_cnt      <= snooze_cnt + 2'd1;
          state           <= SNOOZED;
          ringing_r       <= 1'b0;
          snooze_active_r <= 1'b1;
        end else if (ring_start) begin
          ring_cnt        <= '0;
          state           <= RINGING;
          ringing_r       <= 1'b1;
          snooze_active_r <= 1'b0;
        end else if ((state == RINGING) && bus.sec_tick) begin
          ring_cnt <= ring_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.set_alarm         = set_alarm_r;
  assign bus.new_alarm_minutes = new_minutes_r;
  assign bus.new_alarm_hours   = new_hours_r;
  assign bus.ringing           = ringing_r;
  assign bus.snooze_active     = snooze_active_r;
  assign bus.snooze_count      = snooze_cnt;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Bench for alarm_ctrl: directed vector table, hand sequences for multi-cycle corners,
// and random stimulus against a time-arithmetic session model.
module tb_alarm_ctrl;
  localparam int SN  = 5;
  localparam int RT  = 60;
  localparam int MAX = 3;
  localparam int S_UNSET = 0, S_ARMED = 1, S_RING = 2, S_SNZ = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  alarm_ctrl_if bus ();
  alarm_ctrl #(.SNOOZE_MIN(SN), .RING_TIMEOUT_S(RT), .MAX_SNOOZES(MAX)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  // Model state: session phase, base/programmed times as integers, snooze and second counts.
  int m_st, m_bm, m_bh, m_nm, m_nh, m_cnt, m_secs;
  bit m_set, m_prev;

  typedef struct {
    bit us; int um; int uh;
    bit trig; bit en; bit snz; bit dis; bit tick;
    int cm; int ch;
    bit e_set; int e_nm; int e_nh; bit e_ring; bit e_snz; int e_cnt;
  } vec_t;

  function automatic logic [31:0] pack(bit s, int nh, int nm, bit r, bit z, int c);
    return {16'b0, s, 5'(nh), 6'(nm), r, z, 2'(c)};
  endfunction

  function automatic logic [31:0] dut_vec();
    return {16'b0, bus.set_alarm, bus.new_alarm_hours, bus.new_alarm_minutes,
            bus.ringing, bus.snooze_active, bus.snooze_count};
  endfunction

  function automatic logic [31:0] mdl_vec();
    return pack(m_set, m_nh, m_nm, m_st == S_RING, m_st == S_SNZ, m_cnt);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = S_UNSET; m_bm = 0; m_bh = 0; m_nm = 0; m_nh = 0;
    m_cnt = 0; m_secs = 0; m_set = 0; m_prev = 0;
  endtask

  task automatic program_time(int h, int m);
    m_set = 1; m_nh = h; m_nm = m;
  endtask

  task automatic end_session();
    program_time(m_bh, m_bm); m_cnt = 0; m_st = S_ARMED;
  endtask

  task automatic model_step();
    bit rise;
    int t;
    rise   = bus.alarm_trigger && !m_prev;
    m_prev = bus.alarm_trigger;
    m_set  = 0;
    if (bus.user_set) begin
      m_bm = int'(bus.user_alarm_minutes); m_bh = int'(bus.user_alarm_hours);
      end_session();
    end else if (m_st == S_UNSET) begin
      m_set = 0;
    end else if (m_st != S_ARMED && (bus.dismiss_btn || !bus.alarm_enable)) begin
      end_session();
    end else if (m_st == S_RING && bus.snooze_btn && m_cnt < MAX) begin
      t = (int'(bus.curr_hours) * 60 + int'(bus.curr_minutes) + SN) % 1440;
      program_time(t / 60, t % 60);
      m_cnt++;
      m_st = S_SNZ;
    end else if (m_st == S_RING && bus.sec_tick && m_secs + 1 == RT) begin
      end_session();
    end else if (m_st != S_RING && rise && bus.alarm_enable) begin
      m_st = S_RING; m_secs = 0;
    end else if (m_st == S_RING && bus.sec_tick) begin
      m_secs++;
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    chk("model", dut_vec(), mdl_vec());
    bus.user_set = 0; bus.snooze_btn = 0; bus.dismiss_btn = 0; bus.sec_tick = 0;
  endtask

  task automatic set_trig(bit v);
    bus.alarm_trigger = v;
    step();
  endtask

  vec_t tbl[18];

  initial begin
    tbl[0]  = '{0,0,0, 1,1,0,0,0, 0,0,   0,0,0,0,0,0};
    tbl[1]  = '{1,30,7, 0,1,0,0,0, 0,0,  1,30,7,0,0,0};
    tbl[2]  = '{0,0,0, 0,1,0,0,0, 0,0,   0,30,7,0,0,0};
    tbl[3]  = '{0,0,0, 1,1,0,0,0, 0,0,   0,30,7,1,0,0};
    tbl[4]  = '{0,0,0, 1,1,0,0,1, 0,0,   0,30,7,1,0,0};
    tbl[5]  = '{0,0,0, 1,1,0,1,0, 0,0,   1,30,7,0,0,0};
    tbl[6]  = '{0,0,0, 1,1,0,0,0, 0,0,   0,30,7,0,0,0};
    tbl[7]  = '{0,0,0, 0,1,0,0,0, 57,23, 0,30,7,0,0,0};
    tbl[8]  = '{0,0,0, 1,1,0,0,0, 57,23, 0,30,7,1,0,0};
    tbl[9]  = '{0,0,0, 1,1,1,0,1, 57,23, 1,2,0,0,1,1};
    tbl[10] = '{0,0,0, 0,1,0,0,0, 0,0,   0,2,0,0,1,1};
    tbl[11] = '{0,0,0, 1,1,0,0,0, 2,0,   0,2,0,1,0,1};
    tbl[12] = '{0,0,0, 1,1,1,1,0, 2,0,   1,30,7,0,0,0};
    tbl[13] = '{0,0,0, 0,1,0,0,0, 0,0,   0,30,7,0,0,0};
    tbl[14] = '{0,0,0, 1,0,0,0,0, 0,0,   0,30,7,0,0,0};
    tbl[15] = '{0,0,0, 0,1,0,0,0, 0,0,   0,30,7,0,0,0};
    tbl[16] = '{0,0,0, 1,1,0,0,0, 0,0,   0,30,7,1,0,0};
    tbl[17] = '{1,0,8, 1,1,0,1,0, 0,0,   1,0,8,0,0,0};

    bus.sec_tick = 0; bus.curr_minutes = 0; bus.curr_hours = 0;
    bus.user_alarm_minutes = 0; bus.user_alarm_hours = 0; bus.user_set = 0;
    bus.alarm_enable = 1; bus.snooze_btn = 0; bus.dismiss_btn = 0; bus.alarm_trigger = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", dut_vec(), 32'h0);
    rst = 1;

    for (int i = 0; i < 18; i++) begin
      bus.user_set = tbl[i].us;
      bus.user_alarm_minutes = 6'(tbl[i].um); bus.user_alarm_hours = 5'(tbl[i].uh);
      bus.alarm_trigger = tbl[i].trig; bus.alarm_enable = tbl[i].en;
      bus.snooze_btn = tbl[i].snz; bus.dismiss_btn = tbl[i].dis; bus.sec_tick = tbl[i].tick;
      bus.curr_minutes = 6'(tbl[i].cm); bus.curr_hours = 5'(tbl[i].ch);
      step();
      chk($sformatf("table[%0d]", i), dut_vec(),
          pack(tbl[i].e_set, tbl[i].e_nh, tbl[i].e_nm, tbl[i].e_ring, tbl[i].e_snz, tbl[i].e_cnt));
    end

    // Snooze limit: three snooze/re-ring cycles, then a fourth snooze is ignored.
    bus.curr_minutes = 10; bus.curr_hours = 10;
    set_trig(0); set_trig(1);
    for (int i = 0; i < 3; i++) begin
      bus.snooze_btn = 1; step();
      set_trig(0); set_trig(1);
    end
    chk("three_snoozes", {30'b0, bus.snooze_count}, 32'd3);
    chk("ringing_after_3", {31'b0, bus.ringing}, 32'd1);
    bus.snooze_btn = 1; step();
    chk("fourth_snooze", dut_vec(), pack(0, 10, 15, 1, 0, 3));

    // Ring timeout: 59 ticks keep ringing, the 60th dismisses back to base.
    bus.user_set = 1; bus.user_alarm_minutes = 30; bus.user_alarm_hours = 7; step();
    set_trig(0); set_trig(1);
    for (int i = 0; i < RT - 1; i++) begin
      bus.sec_tick = 1; step();
    end
    chk("before_timeout", {31'b0, bus.ringing}, 32'd1);
    bus.sec_tick = 1; step();
    chk("timeout", dut_vec(), pack(1, 7, 30, 0, 0, 0));

    // Enable dropped while snoozed counts as a dismiss.
    set_trig(0); set_trig(1);
    bus.snooze_btn = 1; step();
    chk("snoozed", dut_vec(), pack(1, 10, 15, 0, 1, 1));
    bus.alarm_enable = 0; step();
    chk("disable_snoozed", dut_vec(), pack(1, 7, 30, 0, 0, 0));
    bus.alarm_enable = 1;

    // Asynchronous reset mid-ring, then trigger edges stay ignored until user_set.
    set_trig(0); set_trig(1);
    chk("ring_before_rst", {31'b0, bus.ringing}, 32'd1);
    #2 rst = 0;
    #1;
    chk("async_rst", dut_vec(), 32'h0);
    model_reset();
    @(posedge clk);
    #1 rst = 1;
    set_trig(0); set_trig(1);
    chk("unset_edge1", {31'b0, bus.ringing}, 32'd0);
    set_trig(0); set_trig(1);
    chk("unset_edge2", dut_vec(), 32'h0);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      bus.user_set = ($urandom_range(0, 299) == 0);
      bus.user_alarm_minutes = 6'($urandom_range(0, 59));
      bus.user_alarm_hours = 5'($urandom_range(0, 23));
      bus.dismiss_btn = ($urandom_range(0, 199) == 0);
      bus.snooze_btn = ($urandom_range(0, 59) == 0);
      bus.sec_tick = ($urandom_range(0, 2) == 0);
      bus.alarm_enable = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 5) == 0) bus.alarm_trigger = ~bus.alarm_trigger;
      bus.curr_minutes = 6'($urandom_range(0, 59));
      bus.curr_hours = 5'($urandom_range(0, 23));
      if (i == 0) bus.user_set = 1;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alarm_ctrl.md
Name: alarm_ctrl

Overview:
- Sequencing controller for the alarm comparator block. Owns the user-programmed base alarm time.
- Programs the comparator through its set_alarm / new_alarm_* interface.
- Converts its level alarm_trigger into a ring / snooze / dismiss session with a ring timeout and a snooze limit.
- Sits between the user-button logic and the alarm comparator; runs on the clock-core clock.

Parameters:
SNOOZE_MIN, 5, minutes added to the current time on snooze (legal 1..59)
RING_TIMEOUT_S, 60, sec_tick pulses in RINGING before auto-dismiss (legal >=1)
MAX_SNOOZES, 3, snoozes allowed per session; further snoozes are ignored

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
sec_tick  in  1  one-cycle pulse once per second
curr_minutes  in  6  current minutes, 0..59
curr_hours  in  5  current hours, 0..23
user_alarm_minutes  in  6  user alarm minutes, valid with user_set
user_alarm_hours  in  5  user alarm hours, valid with user_set
user_set  in  1  one-cycle pulse: program a new base alarm
alarm_enable  in  1  level; 0 disables ringing
snooze_btn  in  1  one-cycle pulse
dismiss_btn  in  1  one-cycle pulse
alarm_trigger  in  1  level from comparator: current time == programmed time
set_alarm  out  1  one-cycle program strobe to comparator
new_alarm_minutes  out  6  programmed minutes, held between strobes
new_alarm_hours  out  5  programmed hours, held between strobes
ringing  out  1  high while RINGING
snooze_active  out  1  high while SNOOZED
snooze_count  out  2  snoozes used in the current session

Behaviour:
Reset (rst=0, asynchronous):
- State UNSET.
- All outputs 0; base time registers 0; trigger-delay register 0; ring-second counter 0.

All outputs are registered.

Trigger edge:
- trig_rise = alarm_trigger & ~trig_d.
- trig_d is updated every cycle.
- trig_rise is ignored in UNSET.
- Ringing starts only on a rising edge, never on a held level.

Program action (one cycle):
- The cycle after the decision: set_alarm=1, new_alarm_* = target value.
- new_alarm_* keep that value afterwards.

Per-cycle event priority: user_set > dismiss > snooze > ring timeout > trig_rise.

A dismiss is any of:
- dismiss_btn.
- alarm_enable=0 while in RINGING or SNOOZED.
- Ring timeout.

States:
- UNSET
  - user_set: latch base time; program base; snooze_count=0 -> ARMED.
  - All other inputs ignored.
- ARMED
  - trig_rise & alarm_enable -> RINGING; ring counter cleared.
  - user_set: re-latch and program base; stay ARMED.
- RINGING (ringing=1)
  - dismiss: program base; snooze_count=0 -> ARMED.
  - snooze_btn & snooze_count<MAX_SNOOZES: program curr+SNOOZE_MIN; snooze_count+1 -> SNOOZED.
  - snooze_btn at the limit is ignored; keep ringing.
  - Each sec_tick increments the ring counter. When a sec_tick brings the count to RING_TIMEOUT_S, that cycle is a dismiss.
- SNOOZED (snooze_active=1)
  - trig_rise & alarm_enable -> RINGING; ring counter cleared.
  - dismiss: program base; snooze_count=0 -> ARMED.
  - snooze_btn ignored.
- user_set in RINGING or SNOOZED: abort the session; latch and program the new base; snooze_count=0 -> ARMED.

Snooze arithmetic:
- m = curr_minutes + SNOOZE_MIN (7-bit intermediate).
- If m >= 60: minutes = m-60, hours = curr_hours+1, with 24 wrapping to 0.
- Otherwise: minutes = m, hours = curr_hours.

Re-trigger rule:
- Dismissing within the alarm minute re-programs the same value; trigger stays high, no new edge, no re-ring.
- A snooze target always differs from the current minute, so the trigger falls.

Simultaneous events:
- Same cycle as sec_tick: snooze or dismiss wins; the counter does not matter after the state change.
- Reset mid-session: immediate return to UNSET with all outputs 0. The comparator keeps its old value, but trig_rise is ignored until the next user_set.

Test Plan:
- Reset, then user_set 07:30 -> next cycle set_alarm=1, new_alarm=07:30. Drive trigger high -> ringing=1 one cycle after the edge. dismiss -> set_alarm pulse 07:30; ringing=0; state ARMED; trigger held high causes no re-ring.
- Ringing at 23:57, snooze -> set_alarm with new_alarm=00:02, snooze_active=1, snooze_count=1. Trigger edge -> ringing=1.
- Three snooze/ring cycles -> snooze_count=3. Fourth snooze_btn -> ringing stays 1, no set_alarm.
- Ringing with no input, 60 sec_ticks -> on the 60th tick, auto-dismiss: set_alarm base 07:30, ringing=0, snooze_count=0. Fewer than 60 ticks -> still ringing.
- Same-cycle snooze_btn and dismiss_btn -> dismiss wins (base reprogrammed). Same-cycle user_set 08:00 and dismiss -> new_alarm=08:00. alarm_enable=0 while SNOOZED -> base reprogrammed, ARMED. Trigger edge with alarm_enable=0 in ARMED -> no ring.
- rst low mid-RINGING -> all outputs 0 immediately (asynchronous). Trigger edges before the next user_set -> no ring.
